// File: rtl/fir_output_collector.sv
// fir_output_collector: merges per-channel toggle-flagged firengine samples into one tagged FWFT valid/ready stream
module fir_output_collector #(
  parameter int NUM_CHANNELS  = 5,
  parameter int LOG2CHANNELS  = 3,
  parameter int DATA_WIDTH    = 18,
  parameter int LOG2FIFODEPTH = 4,
  parameter int FIFODEPTH     = 16
) (
  input  logic                               iClk,
  input  logic                               iRst,
  input  logic [NUM_CHANNELS-1:0]            iDataChanged,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] iData,
  output logic                               oValid,
  input  logic                               iReady,
  output logic [DATA_WIDTH-1:0]              oData,
  output logic [LOG2CHANNELS-1:0]            oChannel,
  output logic [LOG2FIFODEPTH:0]             oFifoLevel,
  output logic [NUM_CHANNELS-1:0]            oOverflow,
  input  logic [NUM_CHANNELS-1:0]            iClearOverflow
);
  logic [NUM_CHANNELS-1:0]  prevToggle, pending, evt, grantVec;
  logic [DATA_WIDTH-1:0]    hold [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]    memData [FIFODEPTH];
  logic [LOG2CHANNELS-1:0]  memChan [FIFODEPTH];
  logic [LOG2CHANNELS-1:0]  rrPtr, grant;
  logic [LOG2FIFODEPTH-1:0] wrPtr, rdPtr;
  logic                     grantValid, push, pop;

  function automatic logic [LOG2CHANNELS-1:0] wrapIdx(input int v);
    return LOG2CHANNELS'(v % NUM_CHANNELS);
  endfunction

  assign evt = iDataChanged ^ prevToggle;

  // Scan downward so the nearest pending channel after rrPtr wins.
  always_comb begin
    grant = '0;
    grantValid = 1'b0;
    for (int i = NUM_CHANNELS; i >= 1; i--)
      if (pending[wrapIdx(int'(rrPtr) + i)]) begin
        grant = wrapIdx(int'(rrPtr) + i);
        grantValid = 1'b1;
      end
  end

  assign push     = grantValid && oFifoLevel != (LOG2FIFODEPTH+1)'(FIFODEPTH);
  assign pop      = oValid && iReady;
  assign grantVec = NUM_CHANNELS'(push) << grant;
  assign oValid   = oFifoLevel != '0;
  assign oData    = oValid ? memData[rdPtr] : '0;
  assign oChannel = oValid ? memChan[rdPtr] : '0;

  always_ff @(posedge iClk or negedge iRst)
    if (!iRst) begin
      prevToggle <= '0;
      pending    <= '0;
      oOverflow  <= '0;
      rrPtr      <= LOG2CHANNELS'(NUM_CHANNELS - 1);
      wrPtr      <= '0;
      rdPtr      <= '0;
      oFifoLevel <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) hold[c] <= '0;
    end else begin
      prevToggle <= iDataChanged;
      if (push) rrPtr <= grant;
      wrPtr      <= wrPtr + LOG2FIFODEPTH'(push);
      rdPtr      <= rdPtr + LOG2FIFODEPTH'(pop);
      oFifoLevel <= oFifoLevel + (LOG2FIFODEPTH+1)'(push) - (LOG2FIFODEPTH+1)'(pop);
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (evt[c]) begin
          hold[c]    <= iData[c*DATA_WIDTH +: DATA_WIDTH];
          pending[c] <= 1'b1;
        end else if (grantVec[c]) pending[c] <= 1'b0;
        if (evt[c] && pending[c] && !grantVec[c]) oOverflow[c] <= 1'b1;
        else if (iClearOverflow[c]) oOverflow[c] <= 1'b0;
      end
    end

  always_ff @(posedge iClk)
    if (push) begin
      memData[wrPtr] <= hold[grant];
      memChan[wrPtr] <= grant;
    end
endmodule

// File: tb/tb_fir_output_collector.sv
// tb_fir_output_collector: directed scenario checks for fir_output_collector
module tb_fir_output_collector;
  logic        iClk = 1'b0;
  logic        iRst = 1'b0;
  logic [4:0]  iDataChanged = '0;
  logic [89:0] iData = '0;
  logic        oValid;
  logic        iReady = 1'b0;
  logic [17:0] oData;
  logic [2:0]  oChannel;
  logic [4:0]  oFifoLevel;
  logic [4:0]  oOverflow;
  logic [4:0]  iClearOverflow = '0;
  int checks = 0;
  int failures = 0;

  fir_output_collector dut (
    .iClk(iClk), .iRst(iRst), .iDataChanged(iDataChanged), .iData(iData),
    .oValid(oValid), .iReady(iReady), .oData(oData), .oChannel(oChannel),
    .oFifoLevel(oFifoLevel), .oOverflow(oOverflow), .iClearOverflow(iClearOverflow)
  );

  always #5 iClk = ~iClk;

  task automatic tick;
    @(posedge iClk);
    #1;
  endtask

  task automatic send(input int c, input logic [17:0] v);
    iData[c*18 +: 18] = v;
    iDataChanged[c] = ~iDataChanged[c];
  endtask

  task automatic doReset;
    iRst = 1'b0;
    iDataChanged = '0;
    iClearOverflow = '0;
    iReady = 1'b0;
    tick();
    tick();
    iRst = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    iRst = 1'b0;
    tick();
    checks++; if (oValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", oValid); end
    checks++; if (oData !== 18'h0) begin failures++; $display("FAIL reset_data got=%0h exp=0", oData); end
    checks++; if (oChannel !== 3'd0) begin failures++; $display("FAIL reset_chan got=%0d exp=0", oChannel); end
    checks++; if (oFifoLevel !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", oFifoLevel); end
    checks++; if (oOverflow !== 5'd0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", oOverflow); end
  endtask

  task automatic test_single;
    doReset();
    iReady = 1'b1;
    send(2, 18'h10000);
    tick();
    checks++; if (oValid !== 1'b0) begin failures++; $display("FAIL single_early got=%0b exp=0", oValid); end
    tick();
    checks++; if (oValid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0b exp=1", oValid); end
    checks++; if (oChannel !== 3'd2) begin failures++; $display("FAIL single_chan got=%0d exp=2", oChannel); end
    checks++; if (oData !== 18'h10000) begin failures++; $display("FAIL single_data got=%0h exp=10000", oData); end
    tick();
    checks++; if (oValid !== 1'b0) begin failures++; $display("FAIL single_popped got=%0b exp=0", oValid); end
    checks++; if (oFifoLevel !== 5'd0) begin failures++; $display("FAIL single_level got=%0d exp=0", oFifoLevel); end
  endtask

  task automatic test_simultaneous;
    logic [2:0]  expChan [3];
    expChan[0] = 3'd0; expChan[1] = 3'd1; expChan[2] = 3'd4;
    doReset();
    for (int r = 0; r < 2; r++) begin
      iReady = 1'b0;
      send(0, 18'(3*r + 1));
      send(1, 18'(3*r + 2));
      send(4, 18'(3*r + 3));
      repeat (4) tick();
      checks++; if (oFifoLevel !== 5'd3) begin failures++; $display("FAIL simul_level r=%0d got=%0d exp=3", r, oFifoLevel); end
      iReady = 1'b1;
      for (int k = 0; k < 3; k++) begin
        checks++; if (oChannel !== expChan[k]) begin failures++; $display("FAIL simul_chan r=%0d k=%0d got=%0d exp=%0d", r, k, oChannel, expChan[k]); end
        checks++; if (oData !== 18'(3*r + k + 1)) begin failures++; $display("FAIL simul_data r=%0d k=%0d got=%0h exp=%0h", r, k, oData, 3*r + k + 1); end
        tick();
      end
      checks++; if (oValid !== 1'b0) begin failures++; $display("FAIL simul_drained r=%0d got=%0b exp=0", r, oValid); end
    end
  endtask

  task automatic test_overflow;
    doReset();
    for (int i = 0; i < 20; i++) begin
      send(3, 18'(i + 1));
      tick();
      if (i == 16) begin
        checks++; if (oFifoLevel !== 5'd16) begin failures++; $display("FAIL ovf_full_level got=%0d exp=16", oFifoLevel); end
        checks++; if (oOverflow !== 5'b00000) begin failures++; $display("FAIL ovf_not_yet got=%0b exp=00000", oOverflow); end
      end
    end
    checks++; if (oFifoLevel !== 5'd16) begin failures++; $display("FAIL ovf_level got=%0d exp=16", oFifoLevel); end
    checks++; if (oOverflow !== 5'b01000) begin failures++; $display("FAIL ovf_flag got=%0b exp=01000", oOverflow); end
    iClearOverflow[3] = 1'b1;
    tick();
    iClearOverflow[3] = 1'b0;
    checks++; if (oOverflow !== 5'b00000) begin failures++; $display("FAIL ovf_clear got=%0b exp=00000", oOverflow); end
  endtask

  task automatic test_full_pop;
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
    checks++; if (oFifoLevel !== 5'd15) begin failures++; $display("FAIL fullpop_nopush got=%0d exp=15", oFifoLevel); end
    tick();
    checks++; if (oFifoLevel !== 5'd16) begin failures++; $display("FAIL fullpop_push got=%0d exp=16", oFifoLevel); end
    iReady = 1'b1;
    for (int k = 2; k <= 16; k++) begin
      checks++; if (oData !== 18'(k) || oChannel !== 3'd3) begin failures++; $display("FAIL fullpop_head k=%0d got=%0h/%0d exp=%0h/3", k, oData, oChannel, k); end
      tick();
    end
    checks++; if (oData !== 18'd20) begin failures++; $display("FAIL fullpop_latest got=%0h exp=14", oData); end
    tick();
    checks++; if (oValid !== 1'b0) begin failures++; $display("FAIL fullpop_empty got=%0b exp=0", oValid); end
  endtask

  task automatic test_collision;
    doReset();
    send(0, 18'd7);
    tick();
    send(0, 18'd8);
    tick();
    checks++; if (oFifoLevel !== 5'd1) begin failures++; $display("FAIL coll_level1 got=%0d exp=1", oFifoLevel); end
    checks++; if (oOverflow !== 5'b0) begin failures++; $display("FAIL coll_ovf got=%0b exp=0", oOverflow); end
    tick();
    checks++; if (oFifoLevel !== 5'd2) begin failures++; $display("FAIL coll_level2 got=%0d exp=2", oFifoLevel); end
    iReady = 1'b1;
    checks++; if (oData !== 18'd7) begin failures++; $display("FAIL coll_first got=%0h exp=7", oData); end
    tick();
    checks++; if (oData !== 18'd8) begin failures++; $display("FAIL coll_second got=%0h exp=8", oData); end
    tick();
    checks++; if (oValid !== 1'b0 || oOverflow !== 5'b0) begin failures++; $display("FAIL coll_end got=%0b/%0b exp=0/0", oValid, oOverflow); end
  endtask

  task automatic test_async_reset;
    doReset();
    for (int c = 0; c < 5; c++) send(c, 18'(10 + c));
    tick();
    send(1, 18'd21);
    repeat (5) tick();
    checks++; if (oFifoLevel !== 5'd5) begin failures++; $display("FAIL arst_pre_level got=%0d exp=5", oFifoLevel); end
    checks++; if (oOverflow !== 5'b00010) begin failures++; $display("FAIL arst_pre_ovf got=%0b exp=00010", oOverflow); end
    #2;
    iRst = 1'b0;
    iDataChanged = '0;
    #1;
    checks++; if (oValid !== 1'b0) begin failures++; $display("FAIL arst_valid got=%0b exp=0", oValid); end
    checks++; if (oFifoLevel !== 5'd0) begin failures++; $display("FAIL arst_level got=%0d exp=0", oFifoLevel); end
    checks++; if (oOverflow !== 5'd0) begin failures++; $display("FAIL arst_ovf got=%0b exp=0", oOverflow); end
    #3;
    iRst = 1'b1;
    tick();
    send(0, 18'h2abcd);
    tick();
    checks++; if (oValid !== 1'b0) begin failures++; $display("FAIL arst_after_early got=%0b exp=0", oValid); end
    tick();
    checks++; if (oValid !== 1'b1 || oChannel !== 3'd0 || oData !== 18'h2abcd) begin failures++; $display("FAIL arst_after got=%0b/%0d/%0h exp=1/0/2abcd", oValid, oChannel, oData); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_overflow();
    test_full_pop();
    test_collision();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
